// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------------------------
// if_fetch_ctrl
//   Sequencer for the instruction-fetch stage of the MIPS pipeline. After reset it streams a
//   program from a loader into instruction memory, then releases fetch. While running it
//   steers the PC register and the IF/ID register from hazard and branch-resolution inputs,
//   and keeps saturating counts of stall cycles and accepted taken branches.
//
// Ports
//   CLK, RST                 clock (rising edge) and asynchronous active-high reset
//   LOAD_VALID/DATA/LAST     loader word stream; LOAD_READY high while loading
//   HAZARD_STALL             load-use hazard from ID
//   BRANCH_TAKEN             taken branch resolved this cycle
//   MEM_WRITE, IMEM_WADDR,   instruction memory write port (byte address, word aligned)
//   IMEM_WDATA
//   PC_CLEAR, PC_WRITE,      PC register control; PC_SRC 0 = PC+4, 1 = branch target
//   PC_SRC
//   IF_ID_WRITE, IF_ID_FLUSH IF/ID register enable and NOP insertion
//   FETCH_ACTIVE             high in RUN and FLUSH
//   LOAD_OVF                 sticky: program overran the memory without LOAD_LAST
//   STALL_CNT, FLUSH_CNT     saturating event counters
// ---------------------------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter int unsigned IMEM_WORDS   = 256,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_VALID,
    input  logic [31:0]      LOAD_DATA,
    input  logic             LOAD_LAST,
    output logic             LOAD_READY,
    input  logic             HAZARD_STALL,
    input  logic             BRANCH_TAKEN,
    output logic             MEM_WRITE,
    output logic [31:0]      IMEM_WADDR,
    output logic [31:0]      IMEM_WDATA,
    output logic             PC_CLEAR,
    output logic             PC_WRITE,
    output logic             PC_SRC,
    output logic             IF_ID_WRITE,
    output logic             IF_ID_FLUSH,
    output logic             FETCH_ACTIVE,
    output logic             LOAD_OVF,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam int unsigned PTR_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(IMEM_WORDS - 1);
    localparam logic [2:0]       REM_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {StLoad, StRun, StFlush} state_e;

    state_e           state_q;
    logic [PTR_W-1:0] ptr_q;
    logic             ovf_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [2:0]       rem_q;       // bubbles still owed after the current one

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StLoad;
            ptr_q       <= '0;
            ovf_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            rem_q       <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (LOAD_VALID) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (LOAD_LAST) begin
                            state_q <= StRun;
                        end else if (ptr_q == PTR_LAST) begin
                            // Last slot written without LAST: keep the word, flag, start.
                            ovf_q   <= 1'b1;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    // Branch outranks a simultaneous stall.
                    if (BRANCH_TAKEN) begin
                        flush_cnt_q <= sat_inc(flush_cnt_q);
                        if (FLUSH_CYCLES > 1) begin
                            state_q <= StFlush;
                            rem_q   <= REM_RELOAD;
                        end
                    end else if (HAZARD_STALL) begin
                        stall_cnt_q <= sat_inc(stall_cnt_q);
                    end
                end
                StFlush: begin
                    if (BRANCH_TAKEN) begin
                        // A new branch restarts the bubble train.
                        flush_cnt_q <= sat_inc(flush_cnt_q);
                        rem_q       <= REM_RELOAD;
                    end else if (rem_q <= 3'd1) begin
                        rem_q   <= '0;
                        state_q <= StRun;
                    end else begin
                        rem_q <= rem_q - 3'd1;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    always_comb begin
        LOAD_READY   = 1'b0;
        MEM_WRITE    = 1'b0;
        IMEM_WADDR   = '0;
        PC_CLEAR     = 1'b0;
        PC_WRITE     = 1'b0;
        PC_SRC       = 1'b0;
        IF_ID_WRITE  = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        FETCH_ACTIVE = 1'b0;
        unique case (state_q)
            StLoad: begin
                LOAD_READY  = 1'b1;
                PC_CLEAR    = 1'b1;
                IF_ID_FLUSH = 1'b1;
                MEM_WRITE   = LOAD_VALID;
                IMEM_WADDR  = 32'({ptr_q, 2'b00});
            end
            StRun: begin
                FETCH_ACTIVE = 1'b1;
                if (BRANCH_TAKEN) begin
                    PC_SRC      = 1'b1;
                    PC_WRITE    = 1'b1;
                    IF_ID_WRITE = 1'b1;
                    IF_ID_FLUSH = 1'b1;
                end else if (!HAZARD_STALL) begin
                    PC_WRITE    = 1'b1;
                    IF_ID_WRITE = 1'b1;
                end
            end
            StFlush: begin
                // Stalls are ignored: the IF/ID contents are being discarded anyway.
                FETCH_ACTIVE = 1'b1;
                PC_WRITE     = 1'b1;
                IF_ID_WRITE  = 1'b1;
                IF_ID_FLUSH  = 1'b1;
                PC_SRC       = BRANCH_TAKEN;
            end
            default: ;
        endcase
    end

    assign IMEM_WDATA = LOAD_DATA;
    assign LOAD_OVF   = ovf_q;
    assign STALL_CNT  = stall_cnt_q;
    assign FLUSH_CNT  = flush_cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_if_fetch_ctrl
//   Self-checking bench. dut_a: IMEM_WORDS=256, FLUSH_CYCLES=2, CNT_W=16.
//   dut_b: IMEM_WORDS=4, FLUSH_CYCLES=1, CNT_W=2. Memory writes are checked against a
//   scoreboard queue filled as loader words are driven.
// ---------------------------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    // {LOAD_READY, PC_CLEAR, MEM_WRITE, PC_WRITE, PC_SRC, IF_ID_WRITE, IF_ID_FLUSH, FETCH_ACTIVE}
    localparam logic [7:0] CTL_LOAD   = 8'b1100_0010;
    localparam logic [7:0] CTL_LOADW  = 8'b1110_0010;
    localparam logic [7:0] CTL_RUN    = 8'b0001_0101;
    localparam logic [7:0] CTL_STALL  = 8'b0000_0001;
    localparam logic [7:0] CTL_BR     = 8'b0001_1111;
    localparam logic [7:0] CTL_FLUSH  = 8'b0001_0111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    wr_t qa[$];
    wr_t qb[$];

    // ---- dut_a ----
    logic        a_rst, a_valid, a_last, a_stall, a_br;
    logic [31:0] a_data;
    logic        a_ready, a_mw, a_pcc, a_pcw, a_pcs, a_ifw, a_iff, a_fa, a_ovf;
    logic [31:0] a_waddr, a_wdata;
    logic [15:0] a_scnt, a_fcnt;
    logic [7:0]  a_ctl;
    assign a_ctl = {a_ready, a_pcc, a_mw, a_pcw, a_pcs, a_ifw, a_iff, a_fa};

    if_fetch_ctrl #(.IMEM_WORDS(256), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
        .CLK(clk), .RST(a_rst), .LOAD_VALID(a_valid), .LOAD_DATA(a_data), .LOAD_LAST(a_last),
        .LOAD_READY(a_ready), .HAZARD_STALL(a_stall), .BRANCH_TAKEN(a_br), .MEM_WRITE(a_mw),
        .IMEM_WADDR(a_waddr), .IMEM_WDATA(a_wdata), .PC_CLEAR(a_pcc), .PC_WRITE(a_pcw),
        .PC_SRC(a_pcs), .IF_ID_WRITE(a_ifw), .IF_ID_FLUSH(a_iff), .FETCH_ACTIVE(a_fa),
        .LOAD_OVF(a_ovf), .STALL_CNT(a_scnt), .FLUSH_CNT(a_fcnt)
    );

    // ---- dut_b ----
    logic        b_rst, b_valid, b_last, b_stall, b_br;
    logic [31:0] b_data;
    logic        b_ready, b_mw, b_pcc, b_pcw, b_pcs, b_ifw, b_iff, b_fa, b_ovf;
    logic [31:0] b_waddr, b_wdata;
    logic [1:0]  b_scnt, b_fcnt;
    logic [7:0]  b_ctl;
    assign b_ctl = {b_ready, b_pcc, b_mw, b_pcw, b_pcs, b_ifw, b_iff, b_fa};

    if_fetch_ctrl #(.IMEM_WORDS(4), .FLUSH_CYCLES(1), .CNT_W(2)) dut_b (
        .CLK(clk), .RST(b_rst), .LOAD_VALID(b_valid), .LOAD_DATA(b_data), .LOAD_LAST(b_last),
        .LOAD_READY(b_ready), .HAZARD_STALL(b_stall), .BRANCH_TAKEN(b_br), .MEM_WRITE(b_mw),
        .IMEM_WADDR(b_waddr), .IMEM_WDATA(b_wdata), .PC_CLEAR(b_pcc), .PC_WRITE(b_pcw),
        .PC_SRC(b_pcs), .IF_ID_WRITE(b_ifw), .IF_ID_FLUSH(b_iff), .FETCH_ACTIVE(b_fa),
        .LOAD_OVF(b_ovf), .STALL_CNT(b_scnt), .FLUSH_CNT(b_fcnt)
    );

    // Scoreboard monitors: every memory write must match the oldest expected one.
    always @(negedge clk) begin
        if (a_mw) begin
            n_vec++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL a_unexpected_write: got addr %h data %h want no write",
                         a_waddr, a_wdata);
            end else begin
                wr_t e;
                e = qa.pop_front();
                if ({a_waddr, a_wdata} !== {e.addr, e.data}) begin
                    n_err++;
                    $display("FAIL a_write: got %h/%h want %h/%h", a_waddr, a_wdata,
                             e.addr, e.data);
                end
            end
        end
        if (b_mw) begin
            n_vec++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL b_unexpected_write: got addr %h data %h want no write",
                         b_waddr, b_wdata);
            end else begin
                wr_t e;
                e = qb.pop_front();
                if ({b_waddr, b_wdata} !== {e.addr, e.data}) begin
                    n_err++;
                    $display("FAIL b_write: got %h/%h want %h/%h", b_waddr, b_wdata,
                             e.addr, e.data);
                end
            end
        end
    end

    // One clock of stimulus: inputs change 1 after the edge, outputs settle by +4.
    task automatic cyc_a(input logic v, input logic [31:0] d, input logic l,
                         input logic s, input logic b);
        @(posedge clk);
        #1;
        a_valid = v; a_data = d; a_last = l; a_stall = s; a_br = b;
        #3;
    endtask

    task automatic cyc_b(input logic v, input logic [31:0] d, input logic l,
                         input logic s, input logic b);
        @(posedge clk);
        #1;
        b_valid = v; b_data = d; b_last = l; b_stall = s; b_br = b;
        #3;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        a_rst = 1'b1; b_rst = 1'b1;
        #3;
        n_vec++;
        if ({a_ctl, a_waddr, a_ovf, a_scnt, a_fcnt} !== {CTL_LOAD, 32'h0, 1'b0, 16'h0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_a: got ctl %b addr %h ovf %b cnt %h/%h want %b 0 0 0/0",
                     a_ctl, a_waddr, a_ovf, a_scnt, a_fcnt, CTL_LOAD);
        end
        @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;
        #3;
        n_vec++;
        if ({b_ctl, b_waddr, b_ovf, b_scnt, b_fcnt} !== {CTL_LOAD, 32'h0, 1'b0, 2'h0, 2'h0}) begin
            n_err++;
            $display("FAIL reset_b: got ctl %b addr %h ovf %b cnt %h/%h want %b 0 0 0/0",
                     b_ctl, b_waddr, b_ovf, b_scnt, b_fcnt, CTL_LOAD);
        end
    endtask

    task automatic test_load();
        logic [31:0] prog [3];
        prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0003; prog[2] = 32'h0109_5020;
        for (int i = 0; i < 3; i++) begin
            qa.push_back('{addr: 32'(i * 4), data: prog[i]});
            // Stall/branch asserted while loading must be ignored.
            cyc_a(1'b1, prog[i], i == 2, 1'b1, 1'b1);
            n_vec++;
            if (a_ctl !== CTL_LOADW) begin
                n_err++;
                $display("FAIL load_ctl_%0d: got %b want %b", i, a_ctl, CTL_LOADW);
            end
        end
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (a_ctl !== CTL_RUN) begin
            n_err++;
            $display("FAIL load_to_run: got %b want %b", a_ctl, CTL_RUN);
        end
        n_vec++;
        if ({qa.size() == 0, a_scnt, a_fcnt} !== {1'b1, 16'h0, 16'h0}) begin
            n_err++;
            $display("FAIL load_drain: got pending %0d cnt %h/%h want 0 0/0",
                     qa.size(), a_scnt, a_fcnt);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            cyc_a(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            n_vec++;
            if (a_ctl !== CTL_STALL) begin
                n_err++;
                $display("FAIL stall_ctl_%0d: got %b want %b", i, a_ctl, CTL_STALL);
            end
        end
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({a_ctl, a_scnt} !== {CTL_RUN, 16'd2}) begin
            n_err++;
            $display("FAIL stall_cnt: got ctl %b cnt %0d want %b 2", a_ctl, a_scnt, CTL_RUN);
        end
    endtask

    task automatic test_branch();
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (a_ctl !== CTL_BR) begin
            n_err++;
            $display("FAIL br_ctl: got %b want %b", a_ctl, CTL_BR);
        end
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({a_ctl, a_fcnt} !== {CTL_FLUSH, 16'd1}) begin
            n_err++;
            $display("FAIL br_flush2: got ctl %b cnt %0d want %b 1", a_ctl, a_fcnt, CTL_FLUSH);
        end
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (a_ctl !== CTL_RUN) begin
            n_err++;
            $display("FAIL br_back_run: got %b want %b", a_ctl, CTL_RUN);
        end
        // Branch and stall together: branch wins; stall in FLUSH ignored.
        cyc_a(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (a_ctl !== CTL_BR) begin
            n_err++;
            $display("FAIL br_vs_stall: got %b want %b", a_ctl, CTL_BR);
        end
        cyc_a(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (a_ctl !== CTL_FLUSH) begin
            n_err++;
            $display("FAIL flush_ignores_stall: got %b want %b", a_ctl, CTL_FLUSH);
        end
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({a_ctl, a_scnt, a_fcnt} !== {CTL_RUN, 16'd2, 16'd2}) begin
            n_err++;
            $display("FAIL br_vs_stall_cnt: got ctl %b cnt %0d/%0d want %b 2/2",
                     a_ctl, a_scnt, a_fcnt, CTL_RUN);
        end
    endtask

    task automatic test_back_to_back();
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (a_ctl !== CTL_BR) begin
            n_err++;
            $display("FAIL b2b_flush_branch: got %b want %b", a_ctl, CTL_BR);
        end
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({a_ctl, a_fcnt} !== {CTL_FLUSH, 16'd4}) begin
            n_err++;
            $display("FAIL b2b_extend: got ctl %b cnt %0d want %b 4", a_ctl, a_fcnt, CTL_FLUSH);
        end
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (a_ctl !== CTL_RUN) begin
            n_err++;
            $display("FAIL b2b_end: got %b want %b", a_ctl, CTL_RUN);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) qb.push_back('{addr: 32'(i * 4), data: 32'hA000_0000 + 32'(i)});
            cyc_b(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
            if (i == 3) begin
                n_vec++;
                if ({b_ctl, b_ovf} !== {CTL_LOADW, 1'b0}) begin
                    n_err++;
                    $display("FAIL ovf_last_slot: got ctl %b ovf %b want %b 0",
                             b_ctl, b_ovf, CTL_LOADW);
                end
            end
        end
        n_vec++;
        if ({b_ctl, b_ovf} !== {CTL_RUN, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_set: got ctl %b ovf %b want %b 1", b_ctl, b_ovf, CTL_RUN);
        end
        cyc_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({qb.size() == 0, b_ovf} !== 2'b11) begin
            n_err++;
            $display("FAIL ovf_drain: got pending %0d ovf %b want 0 1", qb.size(), b_ovf);
        end
    endtask

    task automatic test_flush1();
        cyc_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (b_ctl !== CTL_BR) begin
            n_err++;
            $display("FAIL f1_branch: got %b want %b", b_ctl, CTL_BR);
        end
        cyc_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({b_ctl, b_fcnt} !== {CTL_RUN, 2'd1}) begin
            n_err++;
            $display("FAIL f1_single_bubble: got ctl %b cnt %0d want %b 1",
                     b_ctl, b_fcnt, CTL_RUN);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) cyc_b(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({b_ctl, b_scnt} !== {CTL_RUN, 2'd3}) begin
            n_err++;
            $display("FAIL sat_stall: got ctl %b cnt %0d want %b 3", b_ctl, b_scnt, CTL_RUN);
        end
    endtask

    task automatic test_mid_load_reset();
        @(posedge clk);
        #1;
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        qa.push_back('{addr: 32'h0, data: 32'h1111_1111});
        cyc_a(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        qa.push_back('{addr: 32'h4, data: 32'h2222_2222});
        cyc_a(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({a_ctl, a_waddr} !== {CTL_LOAD, 32'h8}) begin
            n_err++;
            $display("FAIL mid_ptr: got ctl %b addr %h want %b 8", a_ctl, a_waddr, CTL_LOAD);
        end
        #1;
        a_rst = 1'b1;
        #1;
        n_vec++;
        if ({a_ctl, a_waddr, a_scnt, a_fcnt} !== {CTL_LOAD, 32'h0, 16'h0, 16'h0}) begin
            n_err++;
            $display("FAIL mid_async_rst: got ctl %b addr %h cnt %h/%h want %b 0 0/0",
                     a_ctl, a_waddr, a_scnt, a_fcnt, CTL_LOAD);
        end
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        qa.push_back('{addr: 32'h0, data: 32'h3333_3333});
        cyc_a(1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0);
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({a_ctl, a_ovf, a_scnt, a_fcnt, qa.size() == 0} !==
            {CTL_RUN, 1'b0, 16'h0, 16'h0, 1'b1}) begin
            n_err++;
            $display("FAIL mid_reload: got ctl %b ovf %b cnt %h/%h pending %0d want %b 0 0/0 0",
                     a_ctl, a_ovf, a_scnt, a_fcnt, qa.size(), CTL_RUN);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_data = '0; a_last = 1'b0; a_stall = 1'b0; a_br = 1'b0;
        b_rst = 1'b1; b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_stall = 1'b0; b_br = 1'b0;
        test_reset();
        test_load();
        test_stall();
        test_branch();
        test_back_to_back();
        test_overflow();
        test_flush1();
        test_saturate();
        test_mid_load_reset();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
